// File: rtl/logic_unit_arbiter.sv
// rtl/logic_unit_arbiter.sv - round-robin arbiter sharing one registered bitwise logic unit
//
// Purpose: grants one of NUM_REQ requesters at a time, executes AND/OR/NOR/XOR
// on its latched operands, and holds the tagged result until it is consumed.
//
// Ports:
//   CLK        clock, all state updates on the rising edge
//   RSTn       synchronous active-low reset
//   REQ_VALID  per-requester request valid
//   REQ_READY  one-hot grant, high only in IDLE for the round-robin winner
//   REQ_OP     packed 2-bit opcodes (00 AND, 01 OR, 10 NOR, 11 XOR)
//   REQ_A      packed operand A, WIDTH bits per requester
//   REQ_B      packed operand B, WIDTH bits per requester
//   RSP_VALID  result valid
//   RSP_READY  consumer accepts the result
//   RSP_DATA   result of the granted operation
//   RSP_ID     index of the requester owning RSP_DATA
//   BUSY       high whenever the unit is not idle
module logic_unit_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4,
  localparam int ID_W   = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     CLK,
  input  logic                     RSTn,
  input  logic [NUM_REQ-1:0]       REQ_VALID,
  output logic [NUM_REQ-1:0]       REQ_READY,
  input  logic [2*NUM_REQ-1:0]     REQ_OP,
  input  logic [WIDTH*NUM_REQ-1:0] REQ_A,
  input  logic [WIDTH*NUM_REQ-1:0] REQ_B,
  output logic                     RSP_VALID,
  input  logic                     RSP_READY,
  output logic [WIDTH-1:0]         RSP_DATA,
  output logic [ID_W-1:0]          RSP_ID,
  output logic                     BUSY
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic [ID_W:0]   NREQ_W   = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_REQ - 1);

  state_e           state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  grant_id_q, grant_id_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;

  logic             found;
  logic [ID_W-1:0]  winner;
  logic [WIDTH-1:0] a_sel, b_sel;
  logic [1:0]       op_sel;
  logic [WIDTH-1:0] result;

  // Search starts at rr_ptr_q and wraps; the first valid index found wins.
  always_comb begin
    logic [ID_W:0] sum;
    found  = 1'b0;
    winner = '0;
    sum    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (sum >= NREQ_W) begin
        sum = sum - NREQ_W;
      end
      if (!found && REQ_VALID[sum[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = sum[ID_W-1:0];
      end
    end
  end

  // Operand/opcode mux for the winner, using constant part-selects.
  always_comb begin
    a_sel  = '0;
    b_sel  = '0;
    op_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        a_sel  = REQ_A[WIDTH*i +: WIDTH];
        b_sel  = REQ_B[WIDTH*i +: WIDTH];
        op_sel = REQ_OP[2*i +: 2];
      end
    end
  end

  always_comb begin
    result = '0;
    case (op_q)
      2'b00:   result = a_q & b_q;
      2'b01:   result = a_q | b_q;
      2'b10:   result = ~(a_q | b_q);
      default: result = a_q ^ b_q;
    endcase
  end

  // Grant is gated by RSTn so nothing is accepted while reset is held.
  always_comb begin
    REQ_READY = '0;
    if (RSTn && (state_q == IDLE) && found) begin
      REQ_READY[winner] = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          a_d        = a_sel;
          b_d        = b_sel;
          op_d       = op_sel;
          grant_id_d = winner;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d  = result;
        rsp_id_d    = grant_id_q;
        rsp_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (RSP_READY) begin
          rsp_valid_d = 1'b0;
          // Pointer advances only on acceptance so a stalled response
          // cannot let the same requester be re-granted early.
          rr_ptr_d    = (grant_id_q == LAST_IDX) ? '0 : grant_id_q + ID_W'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign RSP_VALID = rsp_valid_q;
  assign RSP_DATA  = rsp_data_q;
  assign RSP_ID    = rsp_id_q;
  assign BUSY      = (state_q != IDLE);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb/tb_logic_unit_arbiter.sv - self-checking bench for logic_unit_arbiter
module tb_logic_unit_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic           CLK = 1'b0;
  logic           RSTn;
  logic [N-1:0]   REQ_VALID;
  logic [N-1:0]   REQ_READY;
  logic [2*N-1:0] REQ_OP;
  logic [W*N-1:0] REQ_A;
  logic [W*N-1:0] REQ_B;
  logic           RSP_VALID;
  logic           RSP_READY;
  logic [W-1:0]   RSP_DATA;
  logic [1:0]     RSP_ID;
  logic           BUSY;

  always #5 CLK = ~CLK;

  logic_unit_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_OP(REQ_OP), .REQ_A(REQ_A), .REQ_B(REQ_B),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
    .RSP_DATA(RSP_DATA), .RSP_ID(RSP_ID), .BUSY(BUSY)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (p + k) % N;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] lu(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return ~(a | b);
      default: return a ^ b;
    endcase
  endfunction

  // Transaction model: at most one request in flight; the result becomes
  // visible one edge after acceptance and retires when the consumer takes it.
  bit           m_known    = 0;
  bit           m_inflight = 0;
  int           m_age      = 0;
  int           m_id       = 0;
  int           m_ptr      = 0;
  logic [W-1:0] m_res      = '0;
  logic [W-1:0] m_last_data = '0;
  int           m_last_id  = 0;

  always @(posedge CLK) begin
    cyc++;
    if (!RSTn) begin
      m_known     = 1;
      m_inflight  = 0;
      m_ptr       = 0;
      m_last_data = '0;
      m_last_id   = 0;
    end else if (m_known) begin
      if (!m_inflight) begin
        int w;
        w = pick(REQ_VALID, m_ptr);
        if (w >= 0) begin
          m_inflight = 1;
          m_age      = 0;
          m_id       = w;
          m_res      = lu(REQ_OP[2*w +: 2], REQ_A[W*w +: W], REQ_B[W*w +: W]);
        end
      end else if (m_age == 0) begin
        m_age       = 1;
        m_last_data = m_res;
        m_last_id   = m_id;
      end else if (RSP_READY) begin
        m_inflight = 0;
        m_ptr      = (m_id + 1) % N;
      end
    end
  end

  always @(negedge CLK) begin
    if (m_known) begin
      logic [N-1:0] exp_ready;
      exp_ready = '0;
      if (RSTn && !m_inflight) begin
        int w;
        w = pick(REQ_VALID, m_ptr);
        if (w >= 0) exp_ready[w] = 1'b1;
      end
      chk("req_ready", 32'(REQ_READY), 32'(exp_ready));
      chk("rsp_valid", 32'(RSP_VALID), 32'(m_inflight && m_age >= 1));
      chk("rsp_data", 32'(RSP_DATA), 32'(m_last_data));
      chk("rsp_id", 32'(RSP_ID), 32'(m_last_id));
      chk("busy", 32'(BUSY), 32'(m_inflight));
    end
  end

  int           g_id[$], g_cyc[$], r_id[$], r_cyc[$], rise_cyc[$];
  logic [W-1:0] r_data[$];
  bit           prev_rv = 0;

  always @(negedge CLK) begin
    if (RSTn === 1'b1) begin
      for (int i = 0; i < N; i++) begin
        if (REQ_READY[i] === 1'b1) begin
          g_id.push_back(i);
          g_cyc.push_back(cyc);
        end
      end
      if (RSP_VALID === 1'b1 && RSP_READY) begin
        r_id.push_back(int'(RSP_ID));
        r_data.push_back(RSP_DATA);
        r_cyc.push_back(cyc);
      end
      if (RSP_VALID === 1'b1 && !prev_rv) rise_cyc.push_back(cyc);
    end
    prev_rv = (RSP_VALID === 1'b1);
  end

  task automatic clear_logs();
    g_id.delete(); g_cyc.delete(); r_id.delete(); r_cyc.delete();
    rise_cyc.delete(); r_data.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [1:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b);
    REQ_VALID[i]       = v;
    REQ_OP[2*i +: 2]   = op;
    REQ_A[W*i +: W]    = a;
    REQ_B[W*i +: W]    = b;
  endtask

  int           fair_ids[6] = '{0, 1, 2, 3, 0, 1};
  logic [W-1:0] opc_res[4]  = '{8'h24, 8'hBD, 8'h42, 8'h99};

  initial begin
    RSTn      = 1'b0;
    RSP_READY = 1'b1;
    REQ_VALID = '0;
    REQ_OP    = '0;
    REQ_A     = '0;
    REQ_B     = '0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 2'(i), 8'(8'h10 * i + 3), 8'(8'h5A ^ i));

    // Reset with all requesters valid, then fairness from index 0.
    tick(3);
    clear_logs();
    RSTn = 1'b1;
    @(negedge CLK);
    chk("first_grant", 32'(REQ_READY), 32'h1);
    tick(17);
    REQ_VALID = '0;
    tick(5);
    chk("fair_n_grants", g_id.size(), 6);
    chk("fair_n_rsp", r_id.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < g_id.size()) chk("fair_grant_id", g_id[i], fair_ids[i]);
      if (i < r_id.size()) chk("fair_rsp_id", r_id[i], fair_ids[i]);
      if (i > 0 && i < g_cyc.size()) chk("fair_spacing", g_cyc[i] - g_cyc[i-1], 3);
    end

    // Single NOR from requester 1.
    clear_logs();
    set_req(1, 1'b1, 2'b10, 8'hF0, 8'h0C);
    @(negedge CLK);
    chk("nor_ready", 32'(REQ_READY), 32'h2);
    tick(1);
    REQ_VALID[1] = 1'b0;
    tick(4);
    chk("nor_n_rsp", r_data.size(), 1);
    if (r_data.size() > 0) begin
      chk("nor_data", 32'(r_data[0]), 32'h03);
      chk("nor_id", r_id[0], 1);
    end
    if (rise_cyc.size() > 0 && g_cyc.size() > 0) chk("nor_latency", rise_cyc[0] - g_cyc[0], 2);
    else chk("nor_latency_seen", 0, 1);

    // Opcode coverage on requester 0.
    clear_logs();
    for (int op = 0; op < 4; op++) begin
      set_req(0, 1'b1, 2'(op), 8'hA5, 8'h3C);
      tick(1);
      REQ_VALID[0] = 1'b0;
      tick(3);
    end
    chk("opc_n_rsp", r_data.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < r_data.size()) begin
        chk("opc_data", 32'(r_data[i]), 32'(opc_res[i]));
        chk("opc_id", r_id[i], 0);
      end
    end

    // Serve requester 1 so the pointer lands on 2, then backpressure.
    set_req(1, 1'b1, 2'b00, 8'hFF, 8'hFF);
    tick(1);
    REQ_VALID[1] = 1'b0;
    tick(3);
    clear_logs();
    RSP_READY = 1'b0;
    set_req(0, 1'b1, 2'b01, 8'h11, 8'h22);
    set_req(3, 1'b1, 2'b11, 8'h33, 8'h55);
    @(negedge CLK);
    chk("bp_winner", 32'(REQ_READY), 32'h8);
    tick(1);
    REQ_VALID[3] = 1'b0;
    tick(6);
    chk("bp_hold_valid", 32'(RSP_VALID), 32'h1);
    chk("bp_hold_data", 32'(RSP_DATA), 32'h66);
    chk("bp_hold_id", 32'(RSP_ID), 32'h3);
    chk("bp_hold_busy", 32'(BUSY), 32'h1);
    chk("bp_hold_ready", 32'(REQ_READY), 32'h0);
    RSP_READY = 1'b1;
    tick(1);
    @(negedge CLK);
    chk("bp_next_grant", 32'(REQ_READY), 32'h1);
    tick(1);
    REQ_VALID[0] = 1'b0;
    tick(4);
    chk("bp_n_grants", g_id.size(), 2);
    chk("bp_n_rsp", r_id.size(), 2);
    if (g_id.size() == 2 && r_id.size() == 2) begin
      chk("bp_grant0", g_id[0], 3);
      chk("bp_grant1", g_id[1], 0);
      chk("bp_rsp_data1", 32'(r_data[1]), 32'h33);
      chk("bp_regrant_gap", g_cyc[1] - r_cyc[0], 1);
    end

    // Reset while in EXEC discards the in-flight result.
    clear_logs();
    set_req(2, 1'b1, 2'b00, 8'hFF, 8'h0F);
    tick(1);
    RSTn = 1'b0;
    set_req(0, 1'b1, 2'b10, 8'h00, 8'h00);
    tick(1);
    chk("rst_rsp_valid", 32'(RSP_VALID), 32'h0);
    chk("rst_busy", 32'(BUSY), 32'h0);
    chk("rst_ready", 32'(REQ_READY), 32'h0);
    RSTn = 1'b1;
    @(negedge CLK);
    chk("rst_regrant", 32'(REQ_READY), 32'h1);
    tick(1);
    REQ_VALID = '0;
    tick(4);
    chk("rst_n_rsp", r_id.size(), 1);
    if (r_id.size() > 0) begin
      chk("rst_rsp_id", r_id[0], 0);
      chk("rst_rsp_data", 32'(r_data[0]), 32'hFF);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
